// File: rtl/bus2_arbiter_if.sv
// Bus bundle between the bus2 arbiter, the two cache-side requesters and the memory controller.
// The arbiter connects through the slave modport; the environment drives the master modport.
interface bus2_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic              wready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rvalid;
   logic [1:0]        done;
   logic              err;
   logic [1:0]        m_cmd;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_rvalid;
   logic              m_resp;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, m_rdata, m_rvalid, m_resp,
      output gnt, wready, rdata, rvalid, done, err, m_cmd, m_addr, m_wdata
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, m_rdata, m_rvalid, m_resp,
      input  gnt, wready, rdata, rvalid, done, err, m_cmd, m_addr, m_wdata
   );
endinterface

// File: rtl/bus2_arbiter.sv
// Two-port round-robin arbiter/sequencer issuing full-line reads and writes to the bus2 memory controller.
// Optional watchdog abort is enabled by defining BUS2_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrate REQ at each edge
// WBEAT | streaming write beats 1..BEATS-1 to the controller
// WWAIT | all write beats sent, waiting for M_RESP
// RWAIT | read command sent, collecting BEATS read beats
module bus2_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 16,
   parameter int BEATS   = 8,
   parameter int TIMEOUT = 255
) (
   input logic           CLK,
   input logic           RESET,
   bus2_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   typedef enum logic [1:0] {IDLE, WBEAT, WWAIT, RWAIT} state_t;

   state_t            state, state_d;
   logic              g, g_d;
   logic              last_g, last_g_d;
   logic              win;
   logic              timeout_hit;
   logic [1:0]        g_onehot;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        done_q, done_d;
   logic [1:0]        m_cmd_q, m_cmd_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;

   // last_g holds the most recent winner; on a tie the other requester wins
   assign win      = (bus.req == 2'b11) ? ~last_g : bus.req[1];
   assign g_onehot = g ? 2'b10 : 2'b01;

`ifdef BUS2_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         wd <= '0;
      else if (state == IDLE || (state == RWAIT && bus.m_rvalid))
         wd <= '0;
      else if (state == WWAIT || state == RWAIT)
         wd <= wd + 1'b1;
   end

   // fires on the edge where the count would reach TIMEOUT; a beat or response on that edge wins
   assign timeout_hit = (wd == WD_W'(TIMEOUT - 1)) &&
                        ((state == WWAIT && !bus.m_resp) || (state == RWAIT && !bus.m_rvalid));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         g         <= 1'b0;
         last_g    <= 1'b1;
         cnt       <= '0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         done_q    <= '0;
         m_cmd_q   <= CMD_NOP;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         m_wdata_q <= '0;
         m_addr_q  <= '0;
      end else begin
         state     <= state_d;
         g         <= g_d;
         last_g    <= last_g_d;
         cnt       <= cnt_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         done_q    <= done_d;
         m_cmd_q   <= m_cmd_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         m_wdata_q <= m_wdata_d;
         m_addr_q  <= m_addr_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (|bus.req) state_d = bus.we[win] ? WBEAT : RWAIT;
         WBEAT:   if (cnt == LAST_BEAT) state_d = WWAIT;
         WWAIT:   if (bus.m_resp || timeout_hit) state_d = IDLE;
         RWAIT:   if ((bus.m_rvalid && cnt == LAST_BEAT) || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      g_d       = g;
      last_g_d  = last_g;
      cnt_d     = cnt;
      gnt_d     = gnt_q;
      rdata_d   = rdata_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      rvalid_d  = '0;
      done_d    = '0;
      m_cmd_d   = CMD_NOP;
      err_d     = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               g_d      = win;
               last_g_d = win;
               gnt_d    = win ? 2'b10 : 2'b01;
               m_addr_d = win ? bus.addr1 : bus.addr0;
               if (bus.we[win]) begin
                  m_cmd_d   = CMD_WRITE;
                  m_wdata_d = win ? bus.wdata1 : bus.wdata0;
                  cnt_d     = CNT_W'(1);
               end else begin
                  m_cmd_d = CMD_READ;
                  cnt_d   = '0;
               end
            end
         end
         WBEAT: begin
            m_wdata_d = g ? bus.wdata1 : bus.wdata0;
            cnt_d     = cnt + 1'b1;
         end
         WWAIT: begin
            if (bus.m_resp || timeout_hit) begin
               done_d = g_onehot;
               gnt_d  = '0;
               err_d  = timeout_hit;
            end
         end
         RWAIT: begin
            if (bus.m_rvalid) begin
               rdata_d  = bus.m_rdata;
               rvalid_d = g_onehot;
               cnt_d    = cnt + 1'b1;
               if (cnt == LAST_BEAT) begin
                  done_d = g_onehot;
                  gnt_d  = '0;
               end
            end else if (timeout_hit) begin
               done_d = g_onehot;
               gnt_d  = '0;
               err_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.gnt     = gnt_q;
   assign bus.wready  = (state == WBEAT);
   assign bus.rdata   = rdata_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.m_cmd   = m_cmd_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
endmodule
